renesas_i2c_axi_slave: RTL and testbench

AXI4-Lite responder that converts one AXI-Lite read or write into a single simple register-access request. It drives a request pulse, addr, wdata and wstrb, then waits for op_ack from the register bank. It is the target-side counterpart of the AXI master used by the Renesas I2C traffic generator and sits in front of local control/status register files. One transaction is outstanding at a time.

---
 rtl/renesas_i2c_axi_slave_pkg.sv | 17 +
 rtl/renesas_i2c_axi_slave_if.sv | 39 +++
 rtl/renesas_i2c_axi_slave.sv | 126 ++++++++++++
 tb/tb_renesas_i2c_axi_slave.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/renesas_i2c_axi_slave_pkg.sv
// Shared types and response codes for the Renesas I2C AXI-Lite register-access responder.
package renesas_i2c_axi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_WAIT,
    WR_RESP,
    RD_REQ,
    RD_WAIT,
    RD_RESP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/renesas_i2c_axi_slave_if.sv
// AXI4-Lite channel bundle between an AXI master and renesas_i2c_axi_slave.
interface renesas_i2c_axi_slave_if #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32
);

  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr;
  logic                        s_axi_awvalid;
  logic                        s_axi_awready;
  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata;
  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb;
  logic                        s_axi_wvalid;
  logic                        s_axi_wready;
  logic [1:0]                  s_axi_bresp;
  logic                        s_axi_bvalid;
  logic                        s_axi_bready;
  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr;
  logic                        s_axi_arvalid;
  logic                        s_axi_arready;
  logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata;
  logic [1:0]                  s_axi_rresp;
  logic                        s_axi_rvalid;
  logic                        s_axi_rready;

  modport master (
    output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

  modport slave (
    input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

endinterface

// File: rtl/renesas_i2c_axi_slave.sv
// AXI4-Lite responder turning one read/write into a single req/op_ack register access.
// Optional op_ack timeout with SLVERR response: define RENESAS_I2C_AXI_SLV_TIMEOUT_EN.
module renesas_i2c_axi_slave
  import renesas_i2c_axi_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        s_axi_aclk,
  input  logic                        s_axi_aresetn,
  renesas_i2c_axi_slave_if.slave      axi,
  output logic                        wr_req,
  output logic                        rd_req,
  output logic [AXI_ADDR_WIDTH-1:0]   addr,
  output logic [AXI_DATA_WIDTH-1:0]   wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] wstrb,
  input  logic                        op_ack,
  input  logic [AXI_DATA_WIDTH-1:0]   rdata
);

  state_t state, state_n;
  logic   idle_q;
  logic   aw_held, w_held;
  logic   aw_hs, w_hs, ar_hs;
  logic   to_hit;

  // Readies derive from a registered IDLE flag so they are 0 while in reset.
  assign axi.s_axi_awready = idle_q & ~aw_held;
  assign axi.s_axi_wready  = idle_q & ~w_held;
  assign axi.s_axi_arready = idle_q & ~aw_held & ~w_held
                             & ~axi.s_axi_awvalid & ~axi.s_axi_wvalid;

  assign aw_hs = axi.s_axi_awvalid & axi.s_axi_awready;
  assign w_hs  = axi.s_axi_wvalid  & axi.s_axi_wready;
  assign ar_hs = axi.s_axi_arvalid & axi.s_axi_arready;

`ifdef RENESAS_I2C_AXI_SLV_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  // to_cnt equals the number of WAIT cycles already spent; the TIMEOUT_CYCLES-th
  // WAIT cycle without op_ack ends the wait with SLVERR.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn)                          to_cnt <= '0;
    else if (state == WR_REQ || state == RD_REQ) to_cnt <= '0;
    else if (state == WR_WAIT || state == RD_WAIT) to_cnt <= to_cnt + 1'b1;
  end

  assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_n          = state;
    wr_req           = 1'b0;
    rd_req           = 1'b0;
    axi.s_axi_bvalid = 1'b0;
    axi.s_axi_rvalid = 1'b0;
    case (state)
      IDLE: begin
        if ((aw_held | aw_hs) && (w_held | w_hs)) state_n = WR_REQ;
        else if (ar_hs)                           state_n = RD_REQ;
      end
      WR_REQ: begin
        wr_req  = 1'b1;
        state_n = WR_WAIT;
      end
      WR_WAIT: if (op_ack || to_hit) state_n = WR_RESP;
      WR_RESP: begin
        axi.s_axi_bvalid = 1'b1;
        if (axi.s_axi_bready) state_n = IDLE;
      end
      RD_REQ: begin
        rd_req  = 1'b1;
        state_n = RD_WAIT;
      end
      RD_WAIT: if (op_ack || to_hit) state_n = RD_RESP;
      RD_RESP: begin
        axi.s_axi_rvalid = 1'b1;
        if (axi.s_axi_rready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state           <= IDLE;
      idle_q          <= 1'b0;
      aw_held         <= 1'b0;
      w_held          <= 1'b0;
      addr            <= '0;
      wdata           <= '0;
      wstrb           <= '0;
      axi.s_axi_bresp <= RESP_OKAY;
      axi.s_axi_rresp <= RESP_OKAY;
      axi.s_axi_rdata <= '0;
    end else begin
      state  <= state_n;
      idle_q <= (state_n == IDLE);
      if (aw_hs) begin
        addr    <= axi.s_axi_awaddr;
        aw_held <= 1'b1;
      end
      if (w_hs) begin
        wdata  <= axi.s_axi_wdata;
        wstrb  <= axi.s_axi_wstrb;
        w_held <= 1'b1;
      end
      if (ar_hs) addr <= axi.s_axi_araddr;
      if (state == WR_WAIT && (op_ack || to_hit))
        axi.s_axi_bresp <= op_ack ? RESP_OKAY : RESP_SLVERR;
      if (state == RD_WAIT && (op_ack || to_hit)) begin
        axi.s_axi_rresp <= op_ack ? RESP_OKAY : RESP_SLVERR;
        axi.s_axi_rdata <= op_ack ? rdata : '0;
      end
      if (state != IDLE && state_n == IDLE) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_renesas_i2c_axi_slave.sv
// Self-checking bench for renesas_i2c_axi_slave: directed and random AXI-Lite traffic
// against a word-array register model, plus reset and optional timeout scenarios.
module tb_renesas_i2c_axi_slave;
  import renesas_i2c_axi_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  renesas_i2c_axi_slave_if #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) axi ();

  logic          wr_req, rd_req, op_ack;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, rdata;
  logic [3:0]    wstrb;

  renesas_i2c_axi_slave #(
    .AXI_ADDR_WIDTH(AW),
    .AXI_DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .s_axi_aclk   (clk),
    .s_axi_aresetn(rst_n),
    .axi          (axi),
    .wr_req       (wr_req),
    .rd_req       (rd_req),
    .addr         (addr),
    .wdata        (wdata),
    .wstrb        (wstrb),
    .op_ack       (op_ack),
    .rdata        (rdata)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_fail   = 0;

  logic [31:0] bank  [16];
  logic [31:0] model [16];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // w_lead > 0: W offered w_lead cycles before AW; w_lead < 0: AW leads.
  task automatic axi_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int w_lead, input int ack_dly,
                           input bit stray_ack, input int b_dly, input bit hold_ar);
    int aw_hs, w_hs, req_at, n_req, n_rd, b_first, b_hs, b_len, exp_req, ack_at;
    int aw_start, w_start;
    logic [31:0] req_addr, req_data;
    logic [3:0]  req_strb;
    logic [1:0]  bresp0;
    bit unstable, ready_leak, ar_leak, rdy0;
    aw_hs = -1; w_hs = -1; req_at = -1; n_req = 0; n_rd = 0; b_first = -1; b_hs = -1;
    b_len = 0; unstable = 0; ready_leak = 0; ar_leak = 0; rdy0 = 0; bresp0 = 2'bxx;
    req_addr = '0; req_data = '0; req_strb = '0;
    aw_start = (w_lead > 0) ? w_lead : 0;
    w_start  = (w_lead < 0) ? -w_lead : 0;
    for (int n = 0; n < 100 && b_hs < 0; n++) begin
      axi.s_axi_awaddr  = a;
      axi.s_axi_wdata   = d;
      axi.s_axi_wstrb   = s;
      axi.s_axi_awvalid = (n >= aw_start) && (aw_hs < 0);
      axi.s_axi_wvalid  = (n >= w_start) && (w_hs < 0);
      axi.s_axi_arvalid = hold_ar;
      exp_req = (aw_hs >= 0 && w_hs >= 0) ? ((aw_hs > w_hs) ? aw_hs : w_hs) + 1 : -1;
      ack_at  = (exp_req >= 0) ? exp_req + ack_dly : -1;
      op_ack  = (ack_at >= 0 && n == ack_at) || (stray_ack && exp_req >= 0 && n == exp_req);
      axi.s_axi_bready = (ack_at >= 0) && (n >= ack_at + 1 + b_dly);
      #1;
      if (n == 0) rdy0 = axi.s_axi_awready & axi.s_axi_wready;
      if (wr_req) begin
        n_req = n_req + 1; req_at = n;
        req_addr = addr; req_data = wdata; req_strb = wstrb;
      end
      if (rd_req) n_rd = n_rd + 1;
      if (axi.s_axi_bvalid) begin
        if (b_first < 0) begin b_first = n; bresp0 = axi.s_axi_bresp; end
        else if (axi.s_axi_bresp !== bresp0) unstable = 1;
        b_len = b_len + 1;
        if (axi.s_axi_bready) b_hs = n;
      end
      if (hold_ar && axi.s_axi_arready) ar_leak = 1;
      if (w_hs >= 0 && aw_hs < 0 && axi.s_axi_wready) ready_leak = 1;
      if (aw_hs >= 0 && axi.s_axi_awready) ready_leak = 1;
      if (axi.s_axi_awvalid && axi.s_axi_awready) aw_hs = n;
      if (axi.s_axi_wvalid && axi.s_axi_wready) w_hs = n;
      @(negedge clk);
    end
    axi.s_axi_awvalid = 1'b0; axi.s_axi_wvalid = 1'b0; axi.s_axi_bready = 1'b0; op_ack = 1'b0;
    exp_req = ((aw_hs > w_hs) ? aw_hs : w_hs) + 1;
    check({tag, " idle_ready"}, rdy0, 1);
    check({tag, " wr_req_count"}, n_req + 16 * n_rd, 1);
    check({tag, " wr_req_cycle"}, req_at, exp_req);
    check({tag, " addr"}, req_addr, a);
    check({tag, " wdata"}, req_data, d);
    check({tag, " wstrb"}, req_strb, s);
    check({tag, " bvalid_cycle"}, b_first, exp_req + ack_dly + 1);
    check({tag, " bresp"}, bresp0, RESP_OKAY);
    check({tag, " b_handshake"}, b_hs, exp_req + ack_dly + 1 + b_dly);
    check({tag, " bvalid_len_stable"}, {b_len, 31'd0, unstable}, {b_dly + 1, 32'd0});
    check({tag, " ready_after_hs"}, ready_leak, 0);
    check({tag, " ar_blocked"}, ar_leak, 0);
    bank[req_addr[5:2]] = merge(bank[req_addr[5:2]], req_data, req_strb);
    model[a[5:2]]       = merge(model[a[5:2]], d, s);
  endtask

  // ack_dly == 0 means no op_ack is ever given (timeout path).
  task automatic axi_read(input string tag, input logic [31:0] a, input int ack_dly,
                          input int r_dly);
    int ar_hs, req_at, n_req, n_wr, r_first, r_hs, r_len, exp_req, ack_at, exp_rv;
    logic [31:0] rdata0;
    logic [1:0]  rresp0;
    bit unstable;
    ar_hs = -1; req_at = -1; n_req = 0; n_wr = 0; r_first = -1; r_hs = -1; r_len = 0;
    unstable = 0; rdata0 = 'x; rresp0 = 2'bxx;
    for (int n = 0; n < 100 && r_hs < 0; n++) begin
      axi.s_axi_araddr  = a;
      axi.s_axi_arvalid = (ar_hs < 0);
      exp_req = (ar_hs >= 0) ? ar_hs + 1 : -1;
      ack_at  = (exp_req >= 0 && ack_dly > 0) ? exp_req + ack_dly : -1;
      exp_rv  = (exp_req < 0) ? -1 : (ack_dly > 0) ? ack_at + 1 : exp_req + 1 + TO;
      op_ack  = (ack_at >= 0 && n == ack_at);
      rdata   = op_ack ? bank[addr[5:2]] : $urandom;
      axi.s_axi_rready = (exp_rv >= 0) && (n >= exp_rv + r_dly);
      #1;
      if (rd_req) begin n_req = n_req + 1; req_at = n; end
      if (wr_req) n_wr = n_wr + 1;
      if (axi.s_axi_rvalid) begin
        if (r_first < 0) begin
          r_first = n; rdata0 = axi.s_axi_rdata; rresp0 = axi.s_axi_rresp;
        end else if (axi.s_axi_rdata !== rdata0 || axi.s_axi_rresp !== rresp0) unstable = 1;
        r_len = r_len + 1;
        if (axi.s_axi_rready) r_hs = n;
      end
      if (axi.s_axi_arvalid && axi.s_axi_arready) ar_hs = n;
      @(negedge clk);
    end
    axi.s_axi_arvalid = 1'b0; axi.s_axi_rready = 1'b0; op_ack = 1'b0;
    exp_rv = (ack_dly > 0) ? ar_hs + 1 + ack_dly + 1 : ar_hs + 1 + 1 + TO;
    check({tag, " ar_accept"}, ar_hs, 0);
    check({tag, " rd_req_count"}, n_req + 16 * n_wr, 1);
    check({tag, " rd_req_cycle"}, req_at, 1);
    check({tag, " rvalid_cycle"}, r_first, exp_rv);
    check({tag, " rdata"}, rdata0, (ack_dly > 0) ? model[a[5:2]] : 32'h0);
    check({tag, " rresp"}, rresp0, (ack_dly > 0) ? RESP_OKAY : RESP_SLVERR);
    check({tag, " rvalid_len_stable"}, {r_len, 31'd0, unstable}, {r_dly + 1, 32'd0});
  endtask

  initial begin
    int unsigned kind, widx;
    logic [31:0] d;
    logic [3:0]  s;
    for (int i = 0; i < 16; i++) begin bank[i] = '0; model[i] = '0; end
    bank[2]  = 32'h1234_5678;
    model[2] = 32'h1234_5678;
    axi.s_axi_awaddr = '0; axi.s_axi_awvalid = 0; axi.s_axi_wdata = '0; axi.s_axi_wstrb = '0;
    axi.s_axi_wvalid = 0; axi.s_axi_bready = 0; axi.s_axi_araddr = '0; axi.s_axi_arvalid = 0;
    axi.s_axi_rready = 0; op_ack = 0; rdata = '0;

    repeat (3) @(negedge clk);
    #1;
    check("reset ctrl", {wr_req, rd_req, axi.s_axi_awready, axi.s_axi_wready,
                         axi.s_axi_arready, axi.s_axi_bvalid, axi.s_axi_rvalid}, 0);
    check("reset data", {addr, wdata}, 0);
    check("reset resp", {wstrb, axi.s_axi_bresp, axi.s_axi_rresp, axi.s_axi_rdata}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    axi_write("wr_same_cycle", 32'h10, 32'hA5A5_0001, 4'hF, 0, 3, 0, 0, 0);
    axi_write("wr_w_first", 32'h24, 32'hDEAD_BEEF, 4'h5, 4, 2, 1, 1, 0);
    axi_read("rd_slow_ready", 32'h08, 2, 5);

    axi.s_axi_araddr = 32'h10;
    axi_write("tie_write", 32'h3C, 32'h0BAD_F00D, 4'hA, 0, 1, 0, 2, 1);
    axi_read("tie_read", 32'h10, 1, 0);

    for (int t = 0; t < 24; t++) begin
      kind = $urandom_range(1, 0);
      widx = $urandom_range(15, 0);
      if (kind == 0) begin
        d = $urandom;
        s = 4'($urandom_range(15, 0));
        axi_write("rand_wr", {26'd0, widx[3:0], 2'b00}, d, s, int'($urandom_range(6, 0)) - 3,
                  int'($urandom_range(6, 1)), bit'($urandom_range(1, 0)),
                  int'($urandom_range(3, 0)), 0);
      end else begin
        axi_read("rand_rd", {26'd0, widx[3:0], 2'b00}, int'($urandom_range(TO, 1)),
                 int'($urandom_range(3, 0)));
      end
    end

`ifdef RENESAS_I2C_AXI_SLV_TIMEOUT_EN
    axi_read("rd_timeout", 32'h08, 0, 0);
    op_ack = 1'b1;
    @(negedge clk);
    op_ack = 1'b0;
    #1;
    check("stray_ack_after_timeout", {axi.s_axi_rvalid, axi.s_axi_bvalid}, 0);
    @(negedge clk);
`endif

    // Reset asserted while waiting for op_ack must drop the read silently.
    axi.s_axi_araddr = 32'h08;
    axi.s_axi_arvalid = 1'b1;
    @(negedge clk);
    axi.s_axi_arvalid = 1'b0;
    #1;
    check("rst_mid rd_req", rd_req, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid ctrl", {wr_req, rd_req, axi.s_axi_awready, axi.s_axi_wready,
                           axi.s_axi_arready, axi.s_axi_bvalid, axi.s_axi_rvalid}, 0);
    check("rst_mid addr", addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    op_ack = 1'b1;
    rdata = 32'hFFFF_FFFF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      op_ack = 1'b0;
      #1;
      check("rst_mid no_rvalid", {axi.s_axi_rvalid, axi.s_axi_rdata}, 0);
    end
    axi_read("post_reset_read", 32'h10, 2, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, observed running expected done");
    $fatal(1, "bench time limit");
  end

endmodule
